// File: rtl/bcd_scan_counter.sv
// -----------------------------------------------------------------------------
// bcd_scan_counter
//   N-digit BCD up/down counter with per-digit load and a built-in multiplexed
//   7-segment scan driver. Single clock domain; count and scan rates come from
//   clock-enable ticks, never from derived clocks.
//
//   Optional build macro: LEADING_ZERO_BLANK_EN
//     defined   -> digits above the most significant non-zero digit are blanked
//                  (seg_cat = 8'hFF) while their anode still scans; digit 0 is
//                  never blanked.
//     undefined -> every digit is always displayed, leading zeros included.
//
// Ports
//   clk        system clock
//   rst_n      async active-low reset
//   run        1 = count on tick, 0 = hold (loads allowed)
//   up_dn      1 = count up, 0 = count down
//   clr        sync clear of all digits (highest priority)
//   ld_en      load strobe, effective only while run = 0
//   ld_sel     digit index to load
//   ld_val     BCD value to load (values above 9 saturate to 9)
//   count_bcd  packed digits, digit k at [4k+3:4k], digit 0 = LSD
//   wrap       one-cycle pulse on full-range wrap (all 9s->0s or 0s->9s)
//   seg_an     anodes, active low, exactly one low
//   seg_cat    cathodes, active low, [7] = dp, [6:0] = gfedcba
// -----------------------------------------------------------------------------
module bcd_scan_counter #(
  parameter  int unsigned NUM_DIGITS = 4,
  parameter  int unsigned CLK_HZ     = 100_000_000,
  parameter  int unsigned COUNT_HZ   = 1,
  parameter  int unsigned SCAN_HZ    = 1000,
  localparam int unsigned SELW       = $clog2(NUM_DIGITS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  input  logic                      up_dn,
  input  logic                      clr,
  input  logic                      ld_en,
  input  logic [SELW-1:0]           ld_sel,
  input  logic [3:0]                ld_val,
  output logic [4*NUM_DIGITS-1:0]   count_bcd,
  output logic                      wrap,
  output logic [NUM_DIGITS-1:0]     seg_an,
  output logic [7:0]                seg_cat
);

  localparam int unsigned CNT_DIV  = CLK_HZ / COUNT_HZ;
  localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned CNT_W    = (CNT_DIV  > 1) ? $clog2(CNT_DIV)  : 1;
  localparam int unsigned SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0]               r_cnt_pre;
  logic [SCAN_W-1:0]              r_scan_pre;
  logic [SELW-1:0]                r_idx;
  logic [NUM_DIGITS-1:0][3:0]     r_digits;
  logic                           r_wrap;
  logic [NUM_DIGITS-1:0]          r_an;
  logic [7:0]                     r_cat;

  logic                           w_count_tick;
  logic                           w_scan_tick;
  logic [SELW-1:0]                w_idx_nxt;
  logic [NUM_DIGITS-1:0][3:0]     w_step;
  logic                           w_carry;
  logic [3:0]                     w_ld_sat;
  logic                           w_ld_hit;
  logic [3:0]                     w_digit_sel;
  logic                           w_blank;
  logic [7:0]                     w_cat_nxt;

  // Active-low 7-segment pattern, dp off; out-of-range digits render as 9
  function automatic logic [7:0] seg_encode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      default: s = 8'h98;
    endcase
    return s;
  endfunction

  assign w_count_tick = run & (r_cnt_pre == CNT_W'(CNT_DIV - 1));
  assign w_scan_tick  = (r_scan_pre == SCAN_W'(SCAN_DIV - 1));

  // Count prescaler: held at 0 while stopped so the first step is a full period after run rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_pre <= '0;
    end else if (!run || w_count_tick) begin
      r_cnt_pre <= '0;
    end else begin
      r_cnt_pre <= r_cnt_pre + CNT_W'(1);
    end
  end

  // Scan prescaler: free running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_pre <= '0;
    end else if (w_scan_tick) begin
      r_scan_pre <= '0;
    end else begin
      r_scan_pre <= r_scan_pre + SCAN_W'(1);
    end
  end

  // One BCD step with ripple carry/borrow; w_carry left set means the whole range wrapped
  always_comb begin
    w_step  = r_digits;
    w_carry = 1'b1;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (w_carry) begin
        if (up_dn) begin
          if (r_digits[k] >= 4'd9) begin
            w_step[k] = 4'd0;
          end else begin
            w_step[k] = r_digits[k] + 4'd1;
            w_carry   = 1'b0;
          end
        end else begin
          if (r_digits[k] == 4'd0) begin
            w_step[k] = 4'd9;
          end else if (r_digits[k] > 4'd9) begin
            w_step[k] = 4'd8;
            w_carry   = 1'b0;
          end else begin
            w_step[k] = r_digits[k] - 4'd1;
            w_carry   = 1'b0;
          end
        end
      end
    end
  end

  assign w_ld_sat = (ld_val > 4'd9) ? 4'd9 : ld_val;
  assign w_ld_hit = (32'(ld_sel) < NUM_DIGITS);

  // Digit register: clear > load > count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits <= '0;
      r_wrap   <= 1'b0;
    end else if (clr) begin
      r_digits <= '0;
      r_wrap   <= 1'b0;
    end else if (!run && ld_en) begin
      r_wrap <= 1'b0;
      if (w_ld_hit) begin
        r_digits[ld_sel] <= w_ld_sat;
      end
    end else if (w_count_tick) begin
      r_digits <= w_step;
      r_wrap   <= w_carry;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign w_idx_nxt   = (r_idx == SELW'(NUM_DIGITS - 1)) ? '0 : r_idx + SELW'(1);
  assign w_digit_sel = r_digits[w_idx_nxt];

`ifdef LEADING_ZERO_BLANK_EN
  // Blank when this digit and every digit above it are zero; digit 0 always shows
  always_comb begin
    w_blank = (w_idx_nxt != '0);
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if ((32'(k) >= 32'(w_idx_nxt)) && (r_digits[k] != 4'd0)) begin
        w_blank = 1'b0;
      end
    end
  end
`else
  assign w_blank = 1'b0;
`endif

  assign w_cat_nxt = w_blank ? 8'hFF : seg_encode(w_digit_sel);

  // Anode and cathode load on the same edge so the display never shows a skewed pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_an  <= {{(NUM_DIGITS - 1){1'b1}}, 1'b0};
      r_cat <= 8'hC0;
    end else if (w_scan_tick) begin
      r_idx <= w_idx_nxt;
      r_an  <= ~(NUM_DIGITS'(1) << w_idx_nxt);
      r_cat <= w_cat_nxt;
    end
  end

  assign count_bcd = r_digits;
  assign wrap      = r_wrap;
  assign seg_an    = r_an;
  assign seg_cat   = r_cat;

endmodule

// File: tb/tb_bcd_scan_counter.sv
module tb_bcd_scan_counter;

  localparam int ND   = 4;
  localparam int CDIV = 10;   // CLK_HZ / COUNT_HZ
  localparam int SDIV = 2;    // CLK_HZ / SCAN_HZ
  localparam int MAXV = 9999;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        up_dn;
  logic        clr;
  logic        ld_en;
  logic [1:0]  ld_sel;
  logic [3:0]  ld_val;
  logic [15:0] count_bcd;
  logic        wrap;
  logic [3:0]  seg_an;
  logic [7:0]  seg_cat;

  int total = 0;
  int bad   = 0;
  int n_mon = 0;

  typedef struct {
    logic [15:0] bcd;
    logic        wrap;
    logic [3:0]  an;
    logic [7:0]  cat;
  } exp_t;

  exp_t exp_q[$];

  logic [7:0] enc [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h98};

  // Reference state: count held as a plain integer 0..9999
  int         m_val;
  int         m_cpre;
  int         m_spre;
  int         m_idx;
  logic       m_wrap;
  logic [7:0] m_cat;

  always #5 clk = ~clk;

  bcd_scan_counter #(
    .NUM_DIGITS (ND),
    .CLK_HZ     (100),
    .COUNT_HZ   (10),
    .SCAN_HZ    (50)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .up_dn     (up_dn),
    .clr       (clr),
    .ld_en     (ld_en),
    .ld_sel    (ld_sel),
    .ld_val    (ld_val),
    .count_bcd (count_bcd),
    .wrap      (wrap),
    .seg_an    (seg_an),
    .seg_cat   (seg_cat)
  );

  function automatic int p10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, req);
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    for (int k = 0; k < ND; k++) e.bcd[4*k +: 4] = 4'((m_val / p10(k)) % 10);
    e.wrap = m_wrap;
    e.an   = ~(4'b0001 << m_idx);
    e.cat  = m_cat;
    return e;
  endfunction

  task automatic model_reset();
    m_val  = 0;
    m_cpre = 0;
    m_spre = 0;
    m_idx  = 0;
    m_wrap = 1'b0;
    m_cat  = 8'hC0;
  endtask

  task automatic model_step();
    bit tick;
    bit stick;
    int old_val;
    int v;
    int p;
    int d;
    tick    = run && (m_cpre == CDIV - 1);
    stick   = (m_spre == SDIV - 1);
    old_val = m_val;
    m_cpre  = run ? (m_cpre + 1) % CDIV : 0;
    m_spre  = (m_spre + 1) % SDIV;
    m_wrap  = 1'b0;
    if (clr) begin
      m_val = 0;
    end else if (!run && ld_en) begin
      v = (ld_val > 4'd9) ? 9 : int'(ld_val);
      p = p10(int'(ld_sel));
      d = (m_val / p) % 10;
      m_val = m_val + (v - d) * p;
    end else if (tick) begin
      if (up_dn) begin
        m_wrap = (m_val == MAXV);
        m_val  = (m_val + 1) % (MAXV + 1);
      end else begin
        m_wrap = (m_val == 0);
        m_val  = (m_val + MAXV) % (MAXV + 1);
      end
    end
    if (stick) begin
      m_idx = (m_idx + 1) % ND;
      m_cat = enc[(old_val / p10(m_idx)) % 10];
`ifdef LEADING_ZERO_BLANK_EN
      if (m_idx != 0 && old_val < p10(m_idx)) m_cat = 8'hFF;
`endif
    end
  endtask

  // Model: one expectation per clock, replaced immediately on async reset
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
        exp_q.delete();
      end else begin
        model_step();
      end
      exp_q.push_back(snap());
    end
  end

  // Monitor: compare DUT outputs against queued expectations mid-cycle
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_mon++;
        cmp("sb_count_bcd", 32'(count_bcd), 32'(e.bcd));
        cmp("sb_wrap",      32'(wrap),      32'(e.wrap));
        cmp("sb_seg_an",    32'(seg_an),    32'(e.an));
        cmp("sb_seg_cat",   32'(seg_cat),   32'(e.cat));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int sel, input logic [3:0] val);
    run    = 1'b0;
    ld_en  = 1'b1;
    ld_sel = 2'(sel);
    ld_val = val;
    cyc();
    ld_en  = 1'b0;
  endtask

  task automatic load_all(input logic [15:0] v);
    for (int k = 0; k < ND; k++) load(k, v[4*k +: 4]);
  endtask

  initial begin
    rst_n = 1'b1; run = 1'b0; up_dn = 1'b1; clr = 1'b0;
    ld_en = 1'b0; ld_sel = 2'd0; ld_val = 4'd0;
    #2 rst_n = 1'b0;
    #1;
    cmp("rst_count_bcd", 32'(count_bcd), 32'h0000);
    cmp("rst_wrap",      32'(wrap),      32'h0);
    cmp("rst_seg_an",    32'(seg_an),    32'hE);
    cmp("rst_seg_cat",   32'(seg_cat),   32'hC0);
    repeat (3) cyc();
    rst_n = 1'b1;

    // 100 clocks counting up: ten ticks
    run = 1'b1; up_dn = 1'b1;
    repeat (100) cyc();
    cmp("up100_count", 32'(count_bcd), 32'h0010);

    // Up-wrap from all nines
    load_all(16'h9999);
    run = 1'b1; up_dn = 1'b1;
    repeat (10) cyc();
    cmp("wrap_up_count", 32'(count_bcd), 32'h0000);
    cmp("wrap_up_pulse", 32'(wrap),      32'h1);
    cyc();
    cmp("wrap_up_end",   32'(wrap),      32'h0);

    // Down-wrap from all zeros
    run = 1'b0;
    cyc();
    up_dn = 1'b0; run = 1'b1;
    repeat (10) cyc();
    cmp("wrap_dn_count", 32'(count_bcd), 32'h9999);
    cmp("wrap_dn_pulse", 32'(wrap),      32'h1);

    // Hold 0120 and let the scan run through several full passes
    load_all(16'h0120);
    repeat (16) cyc();

    // clr coinciding with a count tick that would otherwise wrap
    load_all(16'h9999);
    run = 1'b1; up_dn = 1'b1;
    repeat (9) cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    cmp("clr_tick_count", 32'(count_bcd), 32'h0000);
    cmp("clr_tick_wrap",  32'(wrap),      32'h0);

    // Load value above 9 saturates
    load(2, 4'hC);
    cmp("ld_sat_count", 32'(count_bcd), 32'h0900);

    // Async reset in the middle of counting
    load_all(16'h0457);
    run = 1'b1; up_dn = 1'b1;
    repeat (5) cyc();
    #1 rst_n = 1'b0;
    #1;
    cmp("arst_count_bcd", 32'(count_bcd), 32'h0000);
    cmp("arst_wrap",      32'(wrap),      32'h0);
    cmp("arst_seg_an",    32'(seg_an),    32'hE);
    cmp("arst_seg_cat",   32'(seg_cat),   32'hC0);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (30) cyc();

    // Randomised blocks with occasional near-wrap preloads
    for (int b = 0; b < 40; b++) begin
      up_dn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) load_all(up_dn ? 16'h9998 : 16'h0001);
      run = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < 50; c++) begin
        clr    = ($urandom_range(0, 59) == 0);
        ld_en  = ($urandom_range(0, 4) == 0);
        ld_sel = 2'($urandom);
        ld_val = 4'($urandom);
        cyc();
      end
    end
    clr = 1'b0; ld_en = 1'b0;
    #6;
    cmp("sb_drained", 32'(exp_q.size()), 32'd0);
    cmp("sb_active",  32'(n_mon > 2000), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
